store_retire_buffer: RTL and testbench

Post-retire store FIFO between the retire stage and data memory. Each cycle the retire stage may commit one store (command, size, address, data). This block queues committed stores in order and drains them to Dmem whenever the memory bus arbiter grants a slot. It asserts `full` to stall retirement and `empty` to gate halt reporting, and flags loads whose word address overlaps a pending store so the load path can wait.

---
 rtl/store_retire_buffer_if.sv | 41 ++++
 rtl/store_retire_buffer.sv | 96 +++++++++
 tb/tb_store_retire_buffer.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/store_retire_buffer_if.sv
// Port bundle for the post-retire store FIFO: retire-side enqueue, Dmem-side drain,
// and the load-conflict query. The buffer takes the slave modport.
interface store_retire_buffer_if #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [1:0]       in_command;
  logic [1:0]       in_size;
  logic [XLEN-1:0]  in_addr;
  logic [XLEN-1:0]  in_data;
  logic             full;
  logic             empty;
  logic [CNT_W-1:0] count;
  logic             overflow;

  logic             Dmem_grant;
  logic [1:0]       proc2Dmem_command;
  logic [1:0]       proc2Dmem_size;
  logic [XLEN-1:0]  proc2Dmem_addr;
  logic [XLEN-1:0]  proc2Dmem_data;

  logic             ld_valid;
  logic [XLEN-1:0]  ld_addr;
  logic             ld_conflict;

  modport master (
    output in_command, in_size, in_addr, in_data, Dmem_grant, ld_valid, ld_addr,
    input  full, empty, count, overflow,
    input  proc2Dmem_command, proc2Dmem_size, proc2Dmem_addr, proc2Dmem_data,
    input  ld_conflict
  );

  modport slave (
    input  in_command, in_size, in_addr, in_data, Dmem_grant, ld_valid, ld_addr,
    output full, empty, count, overflow,
    output proc2Dmem_command, proc2Dmem_size, proc2Dmem_addr, proc2Dmem_data,
    output ld_conflict
  );
endinterface

// File: rtl/store_retire_buffer.sv
// In-order queue of committed stores draining to Dmem on arbiter grant; also flags
// loads that hit a pending or incoming store at word granularity.
module store_retire_buffer #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  store_retire_buffer_if.slave  sb
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_STORE = 2'd2;

  logic [1:0]       size_q [DEPTH];
  logic [XLEN-1:0]  addr_q [DEPTH];
  logic [XLEN-1:0]  data_q [DEPTH];
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [CNT_W-1:0] count_q;
  logic             overflow_q;

  logic             full_w;
  logic             empty_w;
  logic             store_req;
  logic             do_enq;
  logic             do_deq;
  logic             pend_hit;
  logic [PTR_W-1:0] off;
  logic             ld_addr_lsb_unused;

  assign full_w    = (count_q == CNT_W'(DEPTH));
  assign empty_w   = (count_q == '0);
  assign store_req = (sb.in_command == BUS_STORE);
  // Full refuses the store even when the head drains in the same cycle.
  assign do_enq    = store_req && !full_w;
  assign do_deq    = !empty_w && sb.Dmem_grant;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (do_enq) tail_q <= tail_q + 1'b1;
      if (do_deq) head_q <= head_q + 1'b1;
      case ({do_enq, do_deq})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (store_req && full_w) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        size_q[i] <= '0;
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else if (do_enq) begin
      size_q[tail_q] <= sb.in_size;
      addr_q[tail_q] <= sb.in_addr;
      data_q[tail_q] <= sb.in_data;
    end
  end

  // Validity is positional: entry i is live when its distance from head is below count.
  always_comb begin
    pend_hit = 1'b0;
    off      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PTR_W'(i) - head_q;
      if ((CNT_W'(off) < count_q) && (addr_q[i][XLEN-1:2] == sb.ld_addr[XLEN-1:2]))
        pend_hit = 1'b1;
    end
  end

  assign ld_addr_lsb_unused = ^sb.ld_addr[1:0];

  assign sb.ld_conflict = sb.ld_valid &&
                          (pend_hit || (store_req && (sb.in_addr[XLEN-1:2] == sb.ld_addr[XLEN-1:2])));

  assign sb.full              = full_w;
  assign sb.empty             = empty_w;
  assign sb.count             = count_q;
  assign sb.overflow          = overflow_q;
  assign sb.proc2Dmem_command = empty_w ? BUS_NONE : BUS_STORE;
  assign sb.proc2Dmem_size    = size_q[head_q];
  assign sb.proc2Dmem_addr    = addr_q[head_q];
  assign sb.proc2Dmem_data    = data_q[head_q];
endmodule

// File: tb/tb_store_retire_buffer.sv
// Directed bench for store_retire_buffer (DEPTH=4, XLEN=32).
module tb_store_retire_buffer;
  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_STORE = 2'd2;
  localparam logic [1:0] SZ_BYTE   = 2'd0;
  localparam logic [1:0] SZ_WORD   = 2'd2;

  logic clock;
  logic reset;
  int   vec;
  int   miss;

  store_retire_buffer_if #(.DEPTH(4), .XLEN(32)) sb ();

  store_retire_buffer #(.DEPTH(4), .XLEN(32)) dut (
    .clock (clock),
    .reset (reset),
    .sb    (sb)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp)
    else begin
      miss++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    sb.in_command = BUS_STORE;
    sb.in_size    = sz;
    sb.in_addr    = a;
    sb.in_data    = d;
  endtask

  task automatic idle_in();
    sb.in_command = BUS_NONE;
    sb.in_size    = '0;
    sb.in_addr    = '0;
    sb.in_data    = '0;
  endtask

  initial begin
    vec  = 0;
    miss = 0;
    reset = 1'b0;
    idle_in();
    sb.Dmem_grant = 1'b0;
    sb.ld_valid   = 1'b0;
    sb.ld_addr    = '0;

    // Reset and idle
    step();
    step();
    chk("rst_empty", 32'(sb.empty), 32'd1);
    chk("rst_count", 32'(sb.count), 32'd0);
    chk("rst_full", 32'(sb.full), 32'd0);
    chk("rst_cmd", 32'(sb.proc2Dmem_command), 32'(BUS_NONE));
    chk("rst_ovf", 32'(sb.overflow), 32'd0);
    reset = 1'b1;
    step();
    chk("idle_empty", 32'(sb.empty), 32'd1);
    chk("idle_cmd", 32'(sb.proc2Dmem_command), 32'(BUS_NONE));

    // Single store, held three cycles without grant, then granted
    drive_store(SZ_WORD, 32'h1000, 32'hDEAD_BEEF);
    step();
    idle_in();
    chk("one_cmd", 32'(sb.proc2Dmem_command), 32'(BUS_STORE));
    chk("one_addr", sb.proc2Dmem_addr, 32'h1000);
    chk("one_data", sb.proc2Dmem_data, 32'hDEAD_BEEF);
    chk("one_size", 32'(sb.proc2Dmem_size), 32'(SZ_WORD));
    chk("one_count", 32'(sb.count), 32'd1);
    step();
    step();
    chk("one_hold_addr", sb.proc2Dmem_addr, 32'h1000);
    chk("one_hold_empty", 32'(sb.empty), 32'd0);
    sb.Dmem_grant = 1'b1;
    step();
    sb.Dmem_grant = 1'b0;
    chk("one_done_empty", 32'(sb.empty), 32'd1);
    chk("one_done_cmd", 32'(sb.proc2Dmem_command), 32'(BUS_NONE));

    // Fill to DEPTH, then overflow with a fifth store
    for (int k = 0; k < 4; k++) begin
      drive_store(SZ_BYTE, 32'h100 + 32'(4 * k), 32'(k + 1));
      step();
    end
    chk("fill_full", 32'(sb.full), 32'd1);
    chk("fill_count", 32'(sb.count), 32'd4);
    chk("fill_ovf_pre", 32'(sb.overflow), 32'd0);
    drive_store(SZ_WORD, 32'h200, 32'h55);
    sb.Dmem_grant = 1'b1;
    step();
    sb.Dmem_grant = 1'b0;
    idle_in();
    chk("ovf_set", 32'(sb.overflow), 32'd1);
    chk("ovf_count", 32'(sb.count), 32'd3);
    chk("ovf_full", 32'(sb.full), 32'd0);
    sb.Dmem_grant = 1'b1;
    for (int k = 1; k < 4; k++) begin
      chk("drain_addr", sb.proc2Dmem_addr, 32'h100 + 32'(4 * k));
      chk("drain_data", sb.proc2Dmem_data, 32'(k + 1));
      step();
    end
    sb.Dmem_grant = 1'b0;
    chk("drain_empty", 32'(sb.empty), 32'd1);
    chk("ovf_sticky", 32'(sb.overflow), 32'd1);

    // Ten back-to-back stores with grant held high
    sb.Dmem_grant = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) begin
        chk("wrap_addr", sb.proc2Dmem_addr, 32'h400 + 32'(4 * (k - 1)));
        chk("wrap_count", 32'(sb.count), 32'd1);
      end
      drive_store(SZ_WORD, 32'h400 + 32'(4 * k), 32'hA0 + 32'(k));
      step();
    end
    idle_in();
    chk("wrap_last_addr", sb.proc2Dmem_addr, 32'h424);
    chk("wrap_last_count", 32'(sb.count), 32'd1);
    step();
    sb.Dmem_grant = 1'b0;
    chk("wrap_empty", 32'(sb.empty), 32'd1);

    // Load conflict against pending, stale and incoming stores
    drive_store(SZ_WORD, 32'h2004, 32'h77);
    step();
    idle_in();
    sb.ld_valid = 1'b1;
    sb.ld_addr  = 32'h2006;
    #1;
    chk("ld_hit_pending", 32'(sb.ld_conflict), 32'd1);
    sb.ld_addr = 32'h2008;
    #1;
    chk("ld_miss_next_word", 32'(sb.ld_conflict), 32'd0);
    sb.ld_addr = 32'h420;
    #1;
    chk("ld_miss_stale", 32'(sb.ld_conflict), 32'd0);
    drive_store(SZ_WORD, 32'h3000, 32'h88);
    sb.ld_addr = 32'h3001;
    #1;
    chk("ld_hit_incoming", 32'(sb.ld_conflict), 32'd1);
    sb.ld_valid = 1'b0;
    #1;
    chk("ld_invalid", 32'(sb.ld_conflict), 32'd0);
    idle_in();
    sb.Dmem_grant = 1'b1;
    step();
    sb.Dmem_grant = 1'b0;
    chk("ld_drain_empty", 32'(sb.empty), 32'd1);

    // Reset pulsed mid-drain
    for (int k = 0; k < 3; k++) begin
      drive_store(SZ_WORD, 32'h500 + 32'(4 * k), 32'(k));
      step();
    end
    idle_in();
    chk("mid_count_pre", 32'(sb.count), 32'd3);
    sb.Dmem_grant = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    chk("mid_count", 32'(sb.count), 32'd0);
    chk("mid_cmd", 32'(sb.proc2Dmem_command), 32'(BUS_NONE));
    chk("mid_ovf", 32'(sb.overflow), 32'd0);
    step();
    chk("mid_hold_empty", 32'(sb.empty), 32'd1);
    reset = 1'b1;
    step();
    chk("mid_after_cmd", 32'(sb.proc2Dmem_command), 32'(BUS_NONE));
    chk("mid_after_count", 32'(sb.count), 32'd0);
    sb.Dmem_grant = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
